booth_seq_divider: RTL and testbench
====================================

Name: booth_seq_divider

Overview:
- Sequential 16-bit integer divider; the inverse-operation companion of the 16-bit Booth radix-8 multiplier.
- Same start/done/busy handshake and same per-operand sign_mode encoding, so one arithmetic front-end can issue to either unit.
- Radix-2 non-performing restoring core on operand magnitudes, followed by sign correction.
- Fixed latency for every operand pair, including divide-by-zero and signed overflow.

Parameters:
- WIDTH, 16, operand/quotient/remainder width; only 16 is verified.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset; the only reset.
- start  in  1  request pulse; sampled only in IDLE.
- dividend  in  WIDTH  numerator.
- divisor  in  WIDTH  denominator.
- sign_mode  in  2  bit1 = dividend signed, bit0 = divisor signed (1 = two's complement, 0 = unsigned).
- quotient  out  WIDTH  registered quotient, truncated toward zero.
- remainder  out  WIDTH  registered remainder; sign follows dividend.
- div_by_zero  out  1  registered flag, valid with done.
- done  out  1  one-cycle pulse; quotient/remainder/div_by_zero valid.
- busy  out  1  high whenever state != IDLE (combinational from state).

Behaviour:
- Reset: state=IDLE; quotient=0, remainder=0, div_by_zero=0, done=0; internal registers cleared. Reset mid-operation aborts; no done is produced.
- Edge E0, IDLE with start=1:
  - latch dividend, divisor, sign_mode;
  - go to PREP;
  - start in any other state is ignored, with no queuing.
- PREP, 1 cycle:
  - neg_n = sign_mode[1] & dividend[15]; neg_d = sign_mode[0] & divisor[15];
  - mag_n = neg_n ? -dividend : dividend; mag_d likewise;
  - both magnitudes are 16-bit unsigned (0x8000 stays 0x8000);
  - zflag = (divisor == 0);
  - clear 17-bit partial remainder R and step counter; go to ITER.
- ITER, exactly 16 cycles, MSB first, per cycle:
  - T = {R[15:0], mag_n[15]} - {1'b0, mag_d} (17-bit);
  - if T non-negative: R = T, shift 1 into quotient; else R = {R[15:0], mag_n[15]}, shift 0;
  - shift mag_n left by one;
  - counter 0..15; on the counter==15 edge go to FIX.
- FIX, 1 cycle, registers outputs, done<=1, state->IDLE:
  - zflag=1: quotient=0xFFFF, remainder=latched dividend, div_by_zero=1;
  - else: quotient = (neg_n^neg_d) ? -Q : Q; remainder = neg_n ? -R[15:0] : R[15:0]; div_by_zero=0.
- Latency: done is high in the cycle after edge E0+18; busy is high for 18 cycles.
- A new start is accepted in the cycle done is high, since state is already IDLE. The resulting done pulses are exactly 19 cycles apart.
- Signed overflow, -32768 / -1 with sign_mode=11: falls out naturally as quotient 0x8000, remainder 0. No flag.
- Outputs hold their last values until the next FIX; done is low outside FIX.
- All arithmetic is explicit-width with zero-extension; signed interpretation is applied only through neg_n/neg_d.

Decomposition:
- Shared package: state localparams IDLE/PREP/ITER/FIX (2-bit); SM_A_SIGNED=1, SM_B_SIGNED=0 bit indices, shared with the multiplier; DIV_ZERO_QUOTIENT all-ones constant.
- One natural sub-module: div_restore_step. Purely combinational; takes R, the next dividend bit and mag_d; returns next R and the quotient bit.
- Top holds the FSM, counter and sign fix-up.

Test Plan:
- sign_mode=00, 100/7 -> quotient=14, remainder=2, div_by_zero=0; done exactly 18 cycles after the start edge; busy high for 18 cycles.
- sign_mode=11, -100/7 (0xFF9C/0x0007) -> quotient=0xFFF2 (-14), remainder=0xFFFE (-2); 100/-7 -> 0xFFF2, 2.
- Mode contrast: 0xFFFF/0x0002 with sign_mode=00 -> 0x7FFF r1; with sign_mode=11 -> 0x0000 r0xFFFF; with sign_mode=10 -> 0x0000 r0xFFFF.
- Boundary cases:
  - sign_mode=11, 0x8000/0xFFFF -> quotient=0x8000, remainder=0;
  - 1234/0 -> quotient=0xFFFF, remainder=0x04D2, div_by_zero=1, same 18-cycle latency.
- Handshake:
  - start held high for 30 cycles gives exactly two done pulses, 19 cycles apart;
  - a second start with new operands 5 cycles into an operation is ignored, and the first result is unchanged.
- Reset mid-ITER, cycle 8: busy=0 and done=0 immediately, outputs 0. A fresh 200/9 then yields 22 r2.

Source files
------------

// File: rtl/booth_seq_divider_pkg.sv
// Shared definitions for the sequential divider and its multiplier sibling.
package booth_seq_divider_pkg;

  localparam int DIV_WIDTH = 16;

  // Bit positions inside sign_mode, identical in the multiplier.
  localparam int SM_A_SIGNED = 1;
  localparam int SM_B_SIGNED = 0;

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/booth_seq_divider_if.sv
// Request/result bundle shared by the divider and whoever issues to it.
// Handshake: start is a request pulse sampled only while the unit is idle;
// busy is high while an operation is in flight; done is a one-cycle pulse
// during which quotient/remainder/div_by_zero are valid (they also hold
// afterwards). There is no backpressure and no queuing of requests.
interface booth_seq_divider_if;
  import booth_seq_divider_pkg::*;

  logic                 start;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic [1:0]           sign_mode;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;
  logic                 div_by_zero;
  logic                 done;
  logic                 busy;

  modport master (
    output start, dividend, divisor, sign_mode,
    input  quotient, remainder, div_by_zero, done, busy
  );

  modport slave (
    input  start, dividend, divisor, sign_mode,
    output quotient, remainder, div_by_zero, done, busy
  );

endinterface

// File: rtl/booth_seq_divider_div_restore_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the difference only when it is non-negative.
// The partial remainder is always below mag_d, so WIDTH bits hold it; the
// extra bit only exists inside the trial subtraction.
module div_restore_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_mag_d,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Trial subtraction and restore select.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift - {1'b0, i_mag_d};
    o_q_bit = ~w_diff[WIDTH];
    o_rem   = o_q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential 16-bit divider: latch, take magnitudes, 16 restoring steps,
// then sign fix-up. Fixed 18-cycle busy window for every operand pair.
module booth_seq_divider
  import booth_seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_seq_divider_if.slave   bus,
  output state_t               o_dbg_state
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [1:0]       r_sign_mode;
  logic             r_neg_n;
  logic             r_neg_d;
  logic             r_zflag;
  logic [WIDTH-1:0] r_mag_n;
  logic [WIDTH-1:0] r_mag_d;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dz;
  logic             r_done;

  logic             w_neg_n;
  logic             w_neg_d;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;

  // Signs come only from sign_mode; magnitudes use plain two's-complement
  // negation so 0x8000 stays 0x8000 as an unsigned magnitude.
  assign w_neg_n = r_sign_mode[SM_A_SIGNED] & r_dividend[WIDTH-1];
  assign w_neg_d = r_sign_mode[SM_B_SIGNED] & r_divisor[WIDTH-1];

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .i_rem   (r_rem),
    .i_bit   (r_mag_n[WIDTH-1]),
    .i_mag_d (r_mag_d),
    .o_rem   (w_rem_next),
    .o_q_bit (w_q_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = PREP;
      PREP:    w_next = ITER;
      ITER:    if (r_cnt == CW'(WIDTH - 1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand capture, magnitude prep, iteration and fix-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_sign_mode <= '0;
      r_neg_n     <= 1'b0;
      r_neg_d     <= 1'b0;
      r_zflag     <= 1'b0;
      r_mag_n     <= '0;
      r_mag_d     <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dz        <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_dividend  <= bus.dividend;
            r_divisor   <= bus.divisor;
            r_sign_mode <= bus.sign_mode;
          end
        end
        PREP: begin
          r_neg_n <= w_neg_n;
          r_neg_d <= w_neg_d;
          r_mag_n <= w_neg_n ? (WIDTH'(0) - r_dividend) : r_dividend;
          r_mag_d <= w_neg_d ? (WIDTH'(0) - r_divisor) : r_divisor;
          r_zflag <= (r_divisor == '0);
          r_rem   <= '0;
          r_q     <= '0;
          r_cnt   <= '0;
        end
        ITER: begin
          r_rem   <= w_rem_next;
          r_q     <= {r_q[WIDTH-2:0], w_q_bit};
          r_mag_n <= {r_mag_n[WIDTH-2:0], 1'b0};
          r_cnt   <= r_cnt + CW'(1);
        end
        FIX: begin
          r_done <= 1'b1;
          if (r_zflag) begin
            r_quotient  <= DIV_ZERO_QUOTIENT;
            r_remainder <= r_dividend;
            r_dz        <= 1'b1;
          end else begin
            r_quotient  <= (r_neg_n ^ r_neg_d) ? (WIDTH'(0) - r_q) : r_q;
            r_remainder <= r_neg_n ? (WIDTH'(0) - r_rem) : r_rem;
            r_dz        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dz;
  assign bus.done        = r_done;
  assign bus.busy        = (r_state != IDLE);
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Self-checking bench for booth_seq_divider: directed cases, handshake
// scenarios and randomized operands against an integer-arithmetic model.
module tb_booth_seq_divider;
  import booth_seq_divider_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     checks;
  int     errors;

  booth_seq_divider_if bus();

  booth_seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer division, C-style truncation toward zero.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic [1:0] sm, output logic [15:0] q,
                                output logic [15:0] r, output logic dz);
    int na;
    int nb;
    if (b == 16'd0) begin
      q  = 16'hFFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      na = sm[1] ? int'($signed(a)) : int'(a);
      nb = sm[0] ? int'($signed(b)) : int'(b);
      q  = 16'(na / nb);
      r  = 16'(na % nb);
      dz = 1'b0;
    end
  endfunction

  // Driver: issue one request and wait (bounded) for done.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] sm, output logic [15:0] q,
                        output logic [15:0] r, output logic dz,
                        output int lat, output int bcyc);
    @(negedge clk);
    bus.dividend  = a;
    bus.divisor   = b;
    bus.sign_mode = sm;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bcyc = bus.busy ? 1 : 0;
    lat  = -1;
    q    = 'x;
    r    = 'x;
    dz   = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        q   = bus.quotient;
        r   = bus.remainder;
        dz  = bus.div_by_zero;
        break;
      end
      if (bus.busy) bcyc++;
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.sign_mode = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (bus.quotient !== 16'h0 || bus.remainder !== 16'h0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got q=%h r=%h dz=%b want q=0000 r=0000 dz=0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_ctrl got done=%b busy=%b state=%0d want done=0 busy=0 state=0",
               bus.done, bus.busy, dbg_state);
    end
  endtask

  // Directed table: basic, signed, mode contrast and boundary cases.
  task automatic test_directed();
    logic [15:0] ta [0:8];
    logic [15:0] tb [0:8];
    logic [1:0]  ts [0:8];
    logic [15:0] eq [0:8];
    logic [15:0] er [0:8];
    logic        ez [0:8];
    logic [15:0] q, r;
    logic        dz;
    int          lat, bcyc;
    ta = '{16'd100, 16'hFF9C, 16'd100, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'd1234, 16'd0};
    tb = '{16'd7,   16'd7,    16'hFFF9, 16'd2,   16'd2,    16'd2,    16'hFFFF, 16'd0,    16'd5};
    ts = '{2'b00,   2'b11,    2'b11,    2'b00,   2'b11,    2'b10,    2'b11,    2'b00,    2'b11};
    eq = '{16'd14,  16'hFFF2, 16'hFFF2, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000, 16'hFFFF, 16'h0};
    er = '{16'd2,   16'hFFFE, 16'd2,    16'd1,    16'hFFFF, 16'hFFFF, 16'h0,    16'h04D2, 16'h0};
    ez = '{1'b0,    1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b0};
    for (int i = 0; i < 9; i++) begin
      run_op(ta[i], tb[i], ts[i], q, r, dz, lat, bcyc);
      checks++;
      if (q !== eq[i] || r !== er[i] || dz !== ez[i]) begin
        errors++;
        $display("FAIL directed_%0d got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                 i, q, r, dz, eq[i], er[i], ez[i]);
      end
      checks++;
      if (lat !== 18 || bcyc !== 18) begin
        errors++;
        $display("FAIL directed_timing_%0d got latency=%0d busy=%0d want latency=18 busy=18",
                 i, lat, bcyc);
      end
    end
  endtask

  // Randomized operands through a scoreboard queue.
  task automatic test_random();
    logic [32:0] exp_q[$];
    logic [32:0] exp;
    logic [15:0] a, b, q, r, mq, mr;
    logic [1:0]  sm;
    logic        dz, mz;
    int          lat, bcyc;
    for (int i = 0; i < 40; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      sm = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: b = 16'h0;
        1: a = 16'h8000;
        2: b = 16'($urandom_range(1, 15));
        3: b = 16'hFFFF;
        default: ;
      endcase
      model(a, b, sm, mq, mr, mz);
      exp_q.push_back({mq, mr, mz});
      run_op(a, b, sm, q, r, dz, lat, bcyc);
      exp = exp_q.pop_front();
      checks++;
      if ({q, r, dz} !== exp || lat !== 18) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h sm=%b got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=18",
                 i, a, b, sm, q, r, dz, lat, exp[32:17], exp[16:1], exp[0]);
      end
    end
  endtask

  // Start held high for 30 cycles: two done pulses 19 cycles apart.
  task automatic test_back_to_back();
    int          ndone;
    int          first_k, second_k;
    logic [15:0] mq, mr, fq;
    logic        mz;
    ndone    = 0;
    first_k  = -1;
    second_k = -1;
    fq       = 'x;
    model(16'd5000, 16'd37, 2'b00, mq, mr, mz);
    @(negedge clk);
    bus.dividend  = 16'd5000;
    bus.divisor   = 16'd37;
    bus.sign_mode = 2'b00;
    bus.start     = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (k == 30) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          first_k = k;
          fq      = bus.quotient;
        end
        if (ndone == 2) second_k = k;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (ndone !== 2 || (second_k - first_k) !== 19) begin
      errors++;
      $display("FAIL back_to_back got pulses=%0d spacing=%0d want pulses=2 spacing=19",
               ndone, second_k - first_k);
    end
    checks++;
    if (fq !== mq) begin
      errors++;
      $display("FAIL back_to_back_result got q=%h want q=%h", fq, mq);
    end
  endtask

  // A second start mid-operation must be ignored entirely.
  task automatic test_ignore_start();
    logic [15:0] mq, mr, q, r;
    logic        mz, dz;
    int          lat, extra;
    model(16'hFF9C, 16'd7, 2'b11, mq, mr, mz);
    lat   = -1;
    extra = 0;
    q     = 'x;
    r     = 'x;
    dz    = 1'bx;
    @(negedge clk);
    bus.dividend  = 16'hFF9C;
    bus.divisor   = 16'd7;
    bus.sign_mode = 2'b11;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) begin
        bus.start     = 1'b1;
        bus.dividend  = 16'd9;
        bus.divisor   = 16'd2;
        bus.sign_mode = 2'b00;
      end
      if (k == 6) bus.start = 1'b0;
      if (bus.done) begin
        lat = k;
        q   = bus.quotient;
        r   = bus.remainder;
        dz  = bus.div_by_zero;
        break;
      end
    end
    checks++;
    if (q !== mq || r !== mr || dz !== mz || lat !== 18) begin
      errors++;
      $display("FAIL ignore_start got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=18",
               q, r, dz, lat, mq, mr, mz);
    end
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_start_queued got active_cycles=%0d want 0", extra);
    end
  endtask

  // Reset in the middle of ITER aborts; a fresh operation still works.
  task automatic test_reset_mid();
    logic [15:0] q, r;
    logic        dz;
    int          lat, bcyc, seen;
    seen = 0;
    @(negedge clk);
    bus.dividend  = 16'd777;
    bus.divisor   = 16'd3;
    bus.sign_mode = 2'b00;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 16'h0 ||
        bus.remainder !== 16'h0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b q=%h r=%h dz=%b want all zero",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_done got done_pulses=%0d want 0", seen);
    end
    run_op(16'd200, 16'd9, 2'b00, q, r, dz, lat, bcyc);
    checks++;
    if (q !== 16'd22 || r !== 16'd2 || dz !== 1'b0 || lat !== 18) begin
      errors++;
      $display("FAIL reset_mid_recover got q=%h r=%h dz=%b lat=%0d want q=0016 r=0002 dz=0 lat=18",
               q, r, dz, lat);
    end
  endtask

  // Test sequence and final report.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
